cand_packer_b: RTL

Packs candidate words into 32-bit words. It sits directly downstream of the word generator's 8-bit output word storage and reads each generated candidate byte by byte. It packs the bytes little-endian into 32-bit words for the hash-core input FIFO and tags each candidate with its packet/word/generator IDs and length. When the candidate is consumed, it releases the storage with `set_empty`.

---
 rtl/cand_packer_b.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cand_packer_b.sv
// Packs candidate bytes from the word storage into little-endian 32-bit words.
// Ports: CLK, rst_n, din/rd_addr/empty/set_empty (storage side), tag inputs,
//   dout/wr_en/full/last/len_out (FIFO side), latched tag outputs.
module cand_packer_b #(
   parameter int WORD_MAX_LEN = 72,
   localparam int AW = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1,
   localparam int LW = $clog2(WORD_MAX_LEN + 1)
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic [7:0]    din,
   output logic [AW-1:0] rd_addr,
   input  logic          empty,
   output logic          set_empty,
   input  logic [15:0]   pkt_id_in,
   input  logic [15:0]   word_id_in,
   input  logic [31:0]   gen_id_in,
   input  logic          gen_end_in,
   output logic [31:0]   dout,
   output logic          wr_en,
   input  logic          full,
   output logic          last,
   output logic [LW-1:0] len_out,
   output logic [15:0]   pkt_id_out,
   output logic [15:0]   word_id_out,
   output logic [31:0]   gen_id_out,
   output logic          gen_end_out
);

   localparam int BW = $clog2(WORD_MAX_LEN + 8);
   localparam logic [AW-1:0] ADDR_MAX = AW'(WORD_MAX_LEN - 1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(WORD_MAX_LEN);
   localparam logic [BW-1:0] POS_END  = BW'(WORD_MAX_LEN);
   localparam logic [BW-1:0] POS_LAST = BW'(WORD_MAX_LEN - 1);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

   state_t        state;
   logic [2:0]    cnt;
   logic [BW-1:0] pos;
   logic [LW-1:0] len;
   logic          term_seen;
   logic [23:0]   acc;

   logic          in_rng;
   logic          cap_ok;
   logic          term_nxt;
   logic [7:0]    lane_b;
   logic [LW-1:0] len_nxt;

   // pos is the byte index of the lane captured this cycle
   always_comb begin
      in_rng   = pos < POS_END;
      cap_ok   = in_rng & ~term_seen & (din != 8'h00);
      lane_b   = cap_ok ? din : 8'h00;
      term_nxt = term_seen | (in_rng & (din == 8'h00));
      len_nxt  = (cap_ok && len != LEN_MAX) ? len + LW'(1) : len;
   end

   assign wr_en     = (state == EMIT) & ~full;
   assign set_empty = wr_en & last;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         pos         <= '0;
         len         <= '0;
         term_seen   <= 1'b0;
         acc         <= '0;
         rd_addr     <= '0;
         dout        <= '0;
         last        <= 1'b0;
         len_out     <= '0;
         pkt_id_out  <= '0;
         word_id_out <= '0;
         gen_id_out  <= '0;
         gen_end_out <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  pkt_id_out  <= pkt_id_in;
                  word_id_out <= word_id_in;
                  gen_id_out  <= gen_id_in;
                  gen_end_out <= gen_end_in;
                  cnt         <= '0;
                  pos         <= '0;
                  len         <= '0;
                  term_seen   <= 1'b0;
                  rd_addr     <= '0;
                  if (gen_end_in) begin
                     dout    <= '0;
                     last    <= 1'b1;
                     len_out <= '0;
                     state   <= EMIT;
                  end else begin
                     last  <= 1'b0;
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               // cnt 0..3 issue reads, cnt 1..4 capture lanes 0..3
               if (cnt != 3'd0) begin
                  pos       <= pos + BW'(1);
                  term_seen <= term_nxt;
                  len       <= len_nxt;
                  if (cnt != 3'd4)
                     acc <= {lane_b, acc[23:8]};
               end
               if (cnt == 3'd4) begin
                  dout    <= {lane_b, acc};
                  last    <= term_nxt | (pos >= POS_LAST);
                  len_out <= len_nxt;
                  state   <= EMIT;
               end else if (rd_addr != ADDR_MAX) begin
                  rd_addr <= rd_addr + AW'(1);
               end
               cnt <= cnt + 3'd1;
            end
            EMIT: begin
               if (!full) begin
                  cnt   <= '0;
                  state <= last ? IDLE : LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
